mem_arbiter: RTL

- Two-to-one memory-port arbiter directly downstream of the data cache and instruction cache; drives the single backing-memory request port.
- Port 0 = icache (read-only refills); port 1 = dcache (refills plus multi-beat writebacks).
- Tags the outgoing request with the source port ID in the MSB and steers responses and nacks back by that bit.
- Write bursts are never interleaved: the grant is locked for all beats of a writeback.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_out_reg.sv | 68 ++++++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encodings
// for the icache/dcache memory arbiter.
package mem_arbiter_pkg;

  localparam logic MEM_ARB_PORT_IC = 1'b0;
  localparam logic MEM_ARB_PORT_DC = 1'b1;

  localparam int MEM_ADDR_BITS_DFLT = 28;
  localparam int MEM_DATA_BITS_DFLT = 64;
  localparam int BURST_BEATS_DFLT = 4;
  localparam int TAG_BITS_DFLT = 2;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_WBURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_out_reg.sv
// One-entry skid-free output register for the memory request port.
// Used only when MEM_ARBITER_OUT_REG_EN is defined.
module mem_arbiter_out_reg
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 64,
   parameter int TAG_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_val_i,
   output logic              in_rdy_o,
   input  logic              in_rw_i,
   input  logic [ADDR_W-1:0] in_addr_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [TAG_W-1:0]  in_tag_i,
   output logic              out_val_o,
   input  logic              out_rdy_i,
   output logic              out_rw_o,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [TAG_W-1:0]  out_tag_o
);

   logic              valid_q, valid_d;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [TAG_W-1:0]  tag_q;
   logic              load;

   assign in_rdy_o = ~valid_q | out_rdy_i;
   assign load     = in_val_i & in_rdy_o;

   always_comb begin
      valid_d = valid_q;
      if (load)
         valid_d = 1'b1;
      else if (out_rdy_i)
         valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload needs no reset; it is qualified by valid_q.
   always_ff @(posedge clk) begin
      if (load) begin
         rw_q   <= in_rw_i;
         addr_q <= in_addr_i;
         data_q <= in_data_i;
         tag_q  <= in_tag_i;
      end
   end

   assign out_val_o  = valid_q;
   assign out_rw_o   = rw_q;
   assign out_addr_o = addr_q;
   assign out_data_o = data_q;
   assign out_tag_o  = tag_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one icache/dcache arbiter onto the backing-memory port.
// Define MEM_ARBITER_OUT_REG_EN to register the memory request side.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DFLT,
   parameter int MEM_DATA_BITS = MEM_DATA_BITS_DFLT,
   parameter int BURST_BEATS   = BURST_BEATS_DFLT,
   parameter int TAG_BITS      = TAG_BITS_DFLT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0_val,
   output logic                     req0_rdy,
   input  logic [MEM_ADDR_BITS-1:0] req0_addr,
   input  logic [TAG_BITS-1:0]      req0_tag,
   input  logic                     req1_val,
   output logic                     req1_rdy,
   input  logic                     req1_rw,
   input  logic [MEM_ADDR_BITS-1:0] req1_addr,
   input  logic [MEM_DATA_BITS-1:0] req1_data,
   input  logic [TAG_BITS-1:0]      req1_tag,
   output logic                     resp0_val,
   output logic                     resp0_nack,
   output logic                     resp1_val,
   output logic                     resp1_nack,
   output logic [MEM_DATA_BITS-1:0] resp_data,
   output logic [TAG_BITS-1:0]      resp_tag,
   output logic                     mem_req_val,
   input  logic                     mem_req_rdy,
   output logic                     mem_req_rw,
   output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
   output logic [MEM_DATA_BITS-1:0] mem_req_data,
   output logic [TAG_BITS:0]        mem_req_tag,
   input  logic                     mem_resp_val,
   input  logic                     mem_resp_nack,
   input  logic [MEM_DATA_BITS-1:0] mem_resp_data,
   input  logic [TAG_BITS:0]        mem_resp_tag
);

   localparam int CNT_W = (BURST_BEATS > 2) ? $clog2(BURST_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

   arb_state_e         state_q, state_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic               last_grant_q, last_grant_d;

   logic                     grant;
   logic                     sel_val;
   logic                     sel_rw;
   logic [MEM_ADDR_BITS-1:0] sel_addr;
   logic [MEM_DATA_BITS-1:0] sel_data;
   logic [TAG_BITS:0]        sel_tag;
   logic                     in_rdy;
   logic                     accept;
   logic                     resp_sel;

   always_comb begin
      grant = MEM_ARB_PORT_IC;
      if (state_q == ARB_WBURST)
         grant = MEM_ARB_PORT_DC;
      else if (req0_val && req1_val)
         grant = ~last_grant_q;
      else if (req1_val)
         grant = MEM_ARB_PORT_DC;
   end

   assign sel_val  = grant ? req1_val : req0_val;
   assign sel_rw   = grant & req1_rw;
   assign sel_addr = grant ? req1_addr : req0_addr;
   assign sel_data = grant ? req1_data : '0;
   assign sel_tag  = {grant, grant ? req1_tag : req0_tag};

   assign accept   = sel_val & in_rdy & ~reset;
   assign req0_rdy = ~grant & in_rdy & ~reset;
   assign req1_rdy = grant & in_rdy & ~reset;

`ifdef MEM_ARBITER_OUT_REG_EN
   logic out_val;

   mem_arbiter_out_reg #(
      .ADDR_W (MEM_ADDR_BITS),
      .DATA_W (MEM_DATA_BITS),
      .TAG_W  (TAG_BITS + 1)
   ) u_out_reg (
      .clk        (clk),
      .reset      (reset),
      .in_val_i   (sel_val & ~reset),
      .in_rdy_o   (in_rdy),
      .in_rw_i    (sel_rw),
      .in_addr_i  (sel_addr),
      .in_data_i  (sel_data),
      .in_tag_i   (sel_tag),
      .out_val_o  (out_val),
      .out_rdy_i  (mem_req_rdy),
      .out_rw_o   (mem_req_rw),
      .out_addr_o (mem_req_addr),
      .out_data_o (mem_req_data),
      .out_tag_o  (mem_req_tag)
   );

   assign mem_req_val = out_val & ~reset;
`else
   assign in_rdy       = mem_req_rdy;
   assign mem_req_val  = sel_val & ~reset;
   assign mem_req_rw   = sel_rw;
   assign mem_req_addr = sel_addr;
   assign mem_req_data = sel_data;
   assign mem_req_tag  = sel_tag;
`endif

   // Burst beats after the first never touch last_grant; port 0 wins next tie.
   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (accept) begin
               last_grant_d = grant;
               if (grant && req1_rw) begin
                  beat_cnt_d = CNT_W'(1);
                  state_d    = ARB_WBURST;
               end
            end
         end
         ARB_WBURST: begin
            if (accept) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  state_d    = ARB_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         beat_cnt_q   <= '0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign resp_sel   = mem_resp_tag[TAG_BITS];
   assign resp0_val  = mem_resp_val & ~resp_sel & ~reset;
   assign resp1_val  = mem_resp_val & resp_sel & ~reset;
   assign resp0_nack = mem_resp_nack & ~resp_sel & ~reset;
   assign resp1_nack = mem_resp_nack & resp_sel & ~reset;
   assign resp_data  = mem_resp_data;
   assign resp_tag   = mem_resp_tag[TAG_BITS-1:0];

endmodule
